// File: rtl/fence_pkg.sv
// Shared types and sizes for the fence coordinate driver.
//   COORD_W     : coordinate width in bits (raw, no sign interpretation)
//   NUM_PTS     : buffered points per set (slot 0 = target, 1..6 = fence)
//   coord_t     : packed {x, y} coordinate pair
//   drv_state_t : driver sequencing states
package fence_pkg;

  localparam int unsigned COORD_W = 10;
  localparam int unsigned NUM_PTS = 7;
  localparam int unsigned IDX_W   = 3;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } coord_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2,
    GAP  = 2'd3
  } drv_state_t;

endpackage

// File: rtl/fence_coord_buf.sv
// Seven-entry coordinate register file with a synchronous clear.
//   clk, rst   : clock, synchronous active-high clear of every entry
//   wr_en      : write strobe (slots >= NUM_PTS are dropped)
//   wr_idx     : write slot
//   wr_data    : coordinate to store
//   rd_idx     : read slot (out-of-range reads return zero)
//   rd_data_c  : combinational read data
module fence_coord_buf
  import fence_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  coord_t           wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output coord_t           rd_data_c
);

  coord_t mem_q [NUM_PTS];

  // Storage: clear has priority over any write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_PTS); i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en && (32'(wr_idx) < NUM_PTS)) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

  // Read port: index one past the last slot yields zero.
  assign rd_data_c = (32'(rd_idx) < NUM_PTS) ? mem_q[rd_idx] : '0;

endmodule

// File: rtl/fence_coord_driver.sv
// Buffers a target point plus six fence points and streams them, one per
// cycle, into fence_system, then waits for its inside/outside verdict.
// Optional WAIT abort is built when FENCE_DRV_TIMEOUT_EN is defined.
//   clk, rst                : clock, synchronous active-high reset
//   wr_en, wr_idx, wr_x/y   : buffer write port (accepted only in IDLE)
//   start                   : stream request (accepted only in IDLE)
//   x_out, y_out            : coordinate stream, zero outside SEND
//   inside_valid, is_inside : verdict handshake (sampled only in WAIT)
//   busy                    : first SEND cycle through GAP
//   res_valid, res_inside   : one-cycle result pulse, held verdict
//   set_cnt, inside_cnt     : wrapping completed-set / inside counters
//   timeout                 : set was aborted (pulses with res_valid)
module fence_coord_driver
  import fence_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [2:0]         wr_idx,
  input  logic [COORD_W-1:0] wr_x,
  input  logic [COORD_W-1:0] wr_y,
  input  logic               start,
  output logic [COORD_W-1:0] x_out,
  output logic [COORD_W-1:0] y_out,
  input  logic               inside_valid,
  input  logic               is_inside,
  output logic               busy,
  output logic               res_valid,
  output logic               res_inside,
  output logic [7:0]         set_cnt,
  output logic [7:0]         inside_cnt,
  output logic               timeout
);

  drv_state_t       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] rd_idx_c;
  logic             buf_we_c;
  logic             wait_hit_c;
  coord_t           wr_data_c;
  coord_t           rd_data_c;
  coord_t           out_d;
  logic             busy_d, res_valid_d, res_inside_d, timeout_d;
  logic [7:0]       set_cnt_d, inside_cnt_d;

  assign wr_data_c = '{x: wr_x, y: wr_y};
  assign buf_we_c  = (state_q == IDLE) && wr_en && (wr_idx != IDX_W'(NUM_PTS));

  // Pre-fetch the slot that goes out on the next cycle.
  assign rd_idx_c = (state_q == SEND) ? idx_q + IDX_W'(1) : '0;

  fence_coord_buf u_buf (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (buf_we_c),
    .wr_idx    (wr_idx),
    .wr_data   (wr_data_c),
    .rd_idx    (rd_idx_c),
    .rd_data_c (rd_data_c)
  );

`ifdef FENCE_DRV_TIMEOUT_EN
  localparam int unsigned WAIT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [WAIT_W-1:0] wait_cnt_q;

  // Counts WAIT cycles; idle at zero elsewhere.
  always_ff @(posedge clk) begin
    if (rst || (state_q != WAIT)) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
    end
  end

  assign wait_hit_c = (state_q == WAIT) && (wait_cnt_q == WAIT_W'(TIMEOUT_CYC - 1));
`else
  assign wait_hit_c = 1'b0;

  // TIMEOUT_CYC has no effect while the abort counter is not built.
  if (TIMEOUT_CYC == 0) begin : g_no_limit
  end
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next state and next registered outputs.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    out_d        = '0;
    res_inside_d = res_inside;
    timeout_d    = 1'b0;
    set_cnt_d    = set_cnt;
    inside_cnt_d = inside_cnt;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SEND;
          idx_d   = '0;
          // A same-cycle write to slot 0 must reach the stream.
          out_d   = (buf_we_c && (wr_idx == '0)) ? wr_data_c : rd_data_c;
        end
      end
      SEND: begin
        if (idx_q == IDX_W'(NUM_PTS - 1)) begin
          state_d = WAIT;
        end else begin
          idx_d = idx_q + IDX_W'(1);
          out_d = rd_data_c;
        end
      end
      WAIT: begin
        // A real verdict beats a timeout on the same cycle.
        if (inside_valid) begin
          state_d      = GAP;
          res_inside_d = is_inside;
        end else if (wait_hit_c) begin
          state_d      = GAP;
          res_inside_d = 1'b0;
          timeout_d    = 1'b1;
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if ((state_q == WAIT) && (state_d == GAP)) begin
      set_cnt_d = set_cnt + 8'd1;
      if (res_inside_d) begin
        inside_cnt_d = inside_cnt + 8'd1;
      end
    end

    busy_d      = (state_d != IDLE);
    res_valid_d = (state_d == GAP);
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_out      <= '0;
      y_out      <= '0;
      busy       <= 1'b0;
      res_valid  <= 1'b0;
      res_inside <= 1'b0;
      timeout    <= 1'b0;
      set_cnt    <= '0;
      inside_cnt <= '0;
    end else begin
      x_out      <= out_d.x;
      y_out      <= out_d.y;
      busy       <= busy_d;
      res_valid  <= res_valid_d;
      res_inside <= res_inside_d;
      timeout    <= timeout_d;
      set_cnt    <= set_cnt_d;
      inside_cnt <= inside_cnt_d;
    end
  end

endmodule

// File: tb/tb_fence_coord_driver.sv
// Directed bench for fence_coord_driver. Timeout cases are compiled in only
// when FENCE_DRV_TIMEOUT_EN is defined (DUT built with TIMEOUT_CYC = 8).
module tb_fence_coord_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [2:0] wr_idx;
  logic [9:0] wr_x, wr_y;
  logic       start;
  logic [9:0] x_out, y_out;
  logic       inside_valid, is_inside;
  logic       busy, res_valid, res_inside, timeout;
  logic [7:0] set_cnt, inside_cnt;

  int n_cmp = 0;
  int n_err = 0;

  logic [9:0] s1x [7];
  logic [9:0] s1y [7];
  logic [9:0] s2x [7];
  logic [9:0] s2y [7];
  logic [9:0] exp_x [7];
  logic [9:0] exp_y [7];

  always #5 clk = ~clk;

  fence_coord_driver #(.TIMEOUT_CYC(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_idx       (wr_idx),
    .wr_x         (wr_x),
    .wr_y         (wr_y),
    .start        (start),
    .x_out        (x_out),
    .y_out        (y_out),
    .inside_valid (inside_valid),
    .is_inside    (is_inside),
    .busy         (busy),
    .res_valid    (res_valid),
    .res_inside   (res_inside),
    .set_cnt      (set_cnt),
    .inside_cnt   (inside_cnt),
    .timeout      (timeout)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_slot(input int k, input logic [9:0] x, input logic [9:0] y);
    wr_en  = 1'b1;
    wr_idx = 3'(k);
    wr_x   = x;
    wr_y   = y;
    step();
    wr_en  = 1'b0;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Called in the first SEND cycle; checks all seven slots against exp_x/exp_y.
  // start_at / iv_at inject ignored stimulus; rst_at aborts with reset.
  task automatic stream_check(input string tag, input int start_at, input int iv_at,
                              input int rst_at);
    for (int k = 0; k < 7; k++) begin
      chk($sformatf("%s_x%0d", tag, k), 32'(x_out), 32'(exp_x[k]));
      chk($sformatf("%s_y%0d", tag, k), 32'(y_out), 32'(exp_y[k]));
      chk($sformatf("%s_busy%0d", tag, k), 32'(busy), 32'd1);
      chk($sformatf("%s_rv%0d", tag, k), 32'(res_valid), 32'd0);
      if (k == rst_at) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        return;
      end
      start        = (k == start_at);
      inside_valid = (k == iv_at);
      is_inside    = 1'b1;
      step();
    end
    start        = 1'b0;
    inside_valid = 1'b0;
    chk({tag, "_x_wait"}, 32'(x_out), 32'd0);
  endtask

  // Called in the first WAIT cycle; responds after dly further cycles.
  task automatic finish_set(input string tag, input int dly, input logic ins);
    for (int d = 0; d < dly; d++) begin
      if (res_valid !== 1'b0) chk({tag, "_early_rv"}, 32'(res_valid), 32'd0);
      step();
    end
    inside_valid = 1'b1;
    is_inside    = ins;
    step();
    inside_valid = 1'b0;
    is_inside    = 1'b0;
    chk({tag, "_rv"}, 32'(res_valid), 32'd1);
    chk({tag, "_ri"}, 32'(res_inside), 32'(ins));
    chk({tag, "_to"}, 32'(timeout), 32'd0);
    chk({tag, "_gap_busy"}, 32'(busy), 32'd1);
    step();
    chk({tag, "_rv_off"}, 32'(res_valid), 32'd0);
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    chk({tag, "_ri_hold"}, 32'(res_inside), 32'(ins));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    s1x = '{10'd3, 10'd7, 10'd6, 10'd10, 10'd16, 10'd3, 10'h3F8};
    s1y = '{10'd3, 10'd0, 10'd2, 10'd14, 10'd28, 10'h3FA, 10'd3};
    s2x = '{10'd3, 10'd0, 10'd6, 10'd8, 10'd6, 10'd2, 10'h3FF};
    s2y = '{10'd3, 10'd0, 10'd0, 10'd4, 10'd8, 10'd6, 10'd3};

    rst = 1'b1; wr_en = 1'b1; wr_idx = 3'd0; wr_x = 10'd5; wr_y = 10'd5;
    start = 1'b1; inside_valid = 1'b0; is_inside = 1'b0;
    step(); step();
    rst = 1'b0; wr_en = 1'b0; start = 1'b0;
    chk("rst_x", 32'(x_out), 32'd0);
    chk("rst_y", 32'(y_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rv", 32'(res_valid), 32'd0);
    chk("rst_ri", 32'(res_inside), 32'd0);
    chk("rst_to", 32'(timeout), 32'd0);
    chk("rst_set", 32'(set_cnt), 32'd0);
    chk("rst_ins", 32'(inside_cnt), 32'd0);
    step();
    chk("rst_start_ign", 32'(busy), 32'd0);

    // Set 1: slot 0 written in the same cycle as start.
    for (int k = 1; k < 7; k++) write_slot(k, s1x[k], s1y[k]);
    write_slot(7, 10'd999, 10'd999);
    exp_x = s1x; exp_y = s1y;
    wr_en = 1'b1; wr_idx = 3'd0; wr_x = s1x[0]; wr_y = s1y[0]; start = 1'b1;
    step();
    wr_en = 1'b0; start = 1'b0;
    stream_check("s1", -1, -1, -1);
    finish_set("s1", 2, 1'b1);
    chk("s1_set", 32'(set_cnt), 32'd1);
    chk("s1_ins", 32'(inside_cnt), 32'd1);

    // Set 2: outside verdict.
    for (int k = 0; k < 7; k++) write_slot(k, s2x[k], s2y[k]);
    exp_x = s2x; exp_y = s2y;
    start_pulse();
    stream_check("s2", -1, -1, -1);
    finish_set("s2", 0, 1'b0);
    chk("s2_set", 32'(set_cnt), 32'd2);
    chk("s2_ins", 32'(inside_cnt), 32'd1);

    // Start and inside_valid during SEND, write during WAIT: all ignored.
    start_pulse();
    stream_check("s3", 2, 3, -1);
    wr_en = 1'b1; wr_idx = 3'd2; wr_x = 10'd999; wr_y = 10'd999;
    step();
    wr_en = 1'b0;
    chk("s3_wait_busy", 32'(busy), 32'd1);
    finish_set("s3", 1, 1'b1);
    chk("s3_set", 32'(set_cnt), 32'd3);
    chk("s3_ins", 32'(inside_cnt), 32'd2);
    start_pulse();
    stream_check("s4", -1, -1, -1);
    finish_set("s4", 0, 1'b0);
    chk("s4_set", 32'(set_cnt), 32'd4);
    chk("s4_ins", 32'(inside_cnt), 32'd2);

    // Reset on slot 4 aborts the set and clears everything.
    start_pulse();
    stream_check("s5", -1, -1, 4);
    chk("abort_x", 32'(x_out), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_rv", 32'(res_valid), 32'd0);
    chk("abort_set", 32'(set_cnt), 32'd0);
    chk("abort_ins", 32'(inside_cnt), 32'd0);
    step();
    chk("abort_rv2", 32'(res_valid), 32'd0);
    for (int k = 0; k < 7; k++) begin
      exp_x[k] = 10'd0;
      exp_y[k] = 10'd0;
    end
    start_pulse();
    stream_check("clr", -1, -1, -1);
    finish_set("clr", 0, 1'b1);
    chk("clr_set", 32'(set_cnt), 32'd1);
    chk("clr_ins", 32'(inside_cnt), 32'd1);

`ifdef FENCE_DRV_TIMEOUT_EN
    // No response: abort after exactly 8 WAIT cycles.
    start_pulse();
    stream_check("to", -1, -1, -1);
    for (int d = 0; d < 8; d++) begin
      chk($sformatf("to_wait_rv%0d", d), 32'(res_valid), 32'd0);
      step();
    end
    chk("to_rv", 32'(res_valid), 32'd1);
    chk("to_flag", 32'(timeout), 32'd1);
    chk("to_ri", 32'(res_inside), 32'd0);
    step();
    chk("to_flag_off", 32'(timeout), 32'd0);
    chk("to_set", 32'(set_cnt), 32'd2);
    chk("to_ins", 32'(inside_cnt), 32'd1);
    // Verdict on the 8th WAIT cycle wins.
    start_pulse();
    stream_check("tie", -1, -1, -1);
    finish_set("tie", 7, 1'b1);
    chk("tie_set", 32'(set_cnt), 32'd3);
    chk("tie_ins", 32'(inside_cnt), 32'd2);
`else
    // WAIT holds indefinitely without the abort counter.
    start_pulse();
    stream_check("long", -1, -1, -1);
    finish_set("long", 100, 1'b0);
    chk("long_set", 32'(set_cnt), 32'd2);
    chk("long_ins", 32'(inside_cnt), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fence_coord_driver.md
FENCE_COORD_DRIVER -- requirements
Module: fence_coord_driver

Interface
REQ-001 The module SHALL have parameter TIMEOUT_CYC, default 64, giving the maximum number of WAIT cycles before abort (used only under FENCE_DRV_TIMEOUT_EN).
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 wr_en  input  1  buffer write strobe.
REQ-005 wr_idx  input  3  buffer slot (0 = target, 1..6 = fence points).
REQ-006 wr_x, wr_y  input  10 each  coordinate written to slot wr_idx.
REQ-007 start  input  1  request to stream the buffered set.
REQ-008 x_out, y_out  output  10 each  coordinate stream; connects to fence_system x_in/y_in.
REQ-009 inside_valid, is_inside  input  1 each  result handshake returned by fence_system.
REQ-010 busy  output  1  high from the first SEND cycle through the GAP cycle.
REQ-011 res_valid  output  1  one-cycle result pulse.
REQ-012 res_inside  output  1  captured is_inside; held until the next res_valid.
REQ-013 set_cnt, inside_cnt  output  8 each  completed sets and inside results; both wrap 255->0.
REQ-014 timeout  output  1  high with res_valid when the set was aborted; the port is always present.

Function
REQ-015 The module SHALL implement the states IDLE, SEND, WAIT and GAP.
REQ-016 In IDLE, wr_en with wr_idx<=6 SHALL write the buffer; wr_idx=7 SHALL be ignored; wr_en in any other state SHALL be ignored.
REQ-017 If wr_en and start are sampled in the same IDLE cycle, the write SHALL complete first, and the stream SHALL use the new value.
REQ-018 start sampled high in IDLE at edge T SHALL enter SEND; slot k SHALL appear on x_out/y_out in cycle T+1+k, k=0..6, with no gaps.
REQ-019 Outside SEND, x_out and y_out SHALL be 0.
REQ-020 After slot 6, the module SHALL enter WAIT; start SHALL be ignored in every state except IDLE.
REQ-021 inside_valid SHALL be ignored in IDLE, SEND and GAP.
REQ-022 In WAIT, inside_valid sampled high SHALL capture is_inside into res_inside and enter GAP.
REQ-023 In the GAP cycle, res_valid SHALL be 1 and set_cnt SHALL increment.
REQ-024 inside_cnt SHALL increment in the GAP cycle when res_inside=1.
REQ-025 GAP SHALL last exactly one cycle, then the module SHALL return to IDLE; a new start SHALL be accepted from the first IDLE cycle.
REQ-026 Coordinates SHALL be passed through bit-exact as 10-bit values; the module SHALL perform no sign interpretation.

Reset
REQ-027 When rst is sampled high, the state SHALL go to IDLE.
REQ-028 On reset, all outputs SHALL be 0, both counters SHALL be 0, the buffer SHALL be cleared to 0, and the WAIT counter SHALL be cleared.
REQ-029 Reset during SEND or WAIT SHALL abort the set with no res_valid and no counter change.
REQ-030 While rst is high, start and wr_en SHALL be ignored.

Configuration
REQ-031 With FENCE_DRV_TIMEOUT_EN defined, a WAIT cycle counter SHALL run.
REQ-032 With FENCE_DRV_TIMEOUT_EN defined, if TIMEOUT_CYC WAIT cycles elapse without inside_valid, the module SHALL enter GAP with res_valid=1, res_inside=0 and timeout=1, and set_cnt SHALL increment.
REQ-033 With FENCE_DRV_TIMEOUT_EN defined, if inside_valid arrives on the same cycle the limit is reached, the valid result SHALL win and timeout SHALL be 0.
REQ-034 Without FENCE_DRV_TIMEOUT_EN, WAIT SHALL be indefinite, timeout SHALL be tied to 0, and no counter logic SHALL be synthesised.

Structure
REQ-035 Package fence_pkg SHALL hold COORD_W=10, NUM_PTS=7, the coord_t struct {x,y}, and the drv_state_t enum.
REQ-036 Sub-module fence_coord_buf SHALL implement the 7-entry coord_t register file (one write port, one read port indexed by the SEND counter, synchronous clear).

Verification
REQ-037 Load (3,3),(7,0),(6,2),(10,14),(16,28),(3,-6),(-8,3); start; model returns inside_valid=1, is_inside=1 three cycles after slot 6 -> stream order exact, res_valid one cycle, res_inside=1, set_cnt=1, inside_cnt=1.
REQ-038 Load (3,3),(0,0),(6,0),(8,4),(6,8),(2,6),(-1,3); start; model returns is_inside=0 -> res_inside=0, set_cnt=2, inside_cnt=1.
REQ-039 start pulsed during SEND, plus wr_en to slot 2 during WAIT -> no restart, buffer unchanged, and the next run replays identical coordinates.
REQ-040 Assert rst in the SEND cycle of slot 4 -> x_out=0 on the next cycle, busy=0, no res_valid, counters 0.
REQ-041 With FENCE_DRV_TIMEOUT_EN and TIMEOUT_CYC=8, the model never responds -> res_valid and timeout=1 exactly 8 cycles after WAIT entry, res_inside=0.
REQ-042 With FENCE_DRV_TIMEOUT_EN and TIMEOUT_CYC=8, inside_valid arrives on the 8th WAIT cycle -> timeout=0.
